// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types, constants and block-count helper for the SHA-256 message padder
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int          BLOCK_WORDS = 16;
  localparam logic [31:0] PAD_WORD    = 32'h8000_0000;

  // Message words + one pad word + two length words, rounded up to whole blocks.
  function automatic int num_blocks(input int nw);
    return (nw + 3 + BLOCK_WORDS - 1) / BLOCK_WORDS;
  endfunction

endpackage

// File: rtl/sha256_pad_word_sel.sv
// rtl/sha256_pad_word_sel.sv - picks message, pad, zero or length word for global word index n
// SHA_PAD_BSWAP_EN: byte-reverse memory words before insertion (pad/length words untouched).
module sha256_pad_word_sel
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic [15:0] n_i,
  input  logic [31:0] mem_word_i,
  output logic [31:0] word_o
);

  localparam int          NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
  localparam logic [15:0] NW_IDX     = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LAST_IDX   = 16'(NUM_BLOCKS * BLOCK_WORDS - 1);
  localparam logic [31:0] LEN_LO     = 32'(NUM_OF_WORDS * 32);

  logic [31:0] msg_word;

`ifdef SHA_PAD_BSWAP_EN
  assign msg_word = {mem_word_i[7:0], mem_word_i[15:8], mem_word_i[23:16], mem_word_i[31:24]};
`else
  assign msg_word = mem_word_i;
`endif

  // The upper length word is always zero for legal lengths, so it falls into the default.
  always_comb begin
    word_o = 32'h0;
    if (n_i < NW_IDX) begin
      word_o = msg_word;
    end else if (n_i == NW_IDX) begin
      word_o = PAD_WORD;
    end else if (n_i == LAST_IDX) begin
      word_o = LEN_LO;
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - reads a message from memory, pads it and emits 512-bit SHA-256 blocks
// Optional build macro SHA_PAD_BSWAP_EN (handled in sha256_pad_word_sel) byte-swaps message words.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic [15:0]  mem_addr,
  output logic         mem_we,
  input  logic [31:0]  mem_read_data,
  output logic [511:0] block_data,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_last,
  output logic [7:0]   block_idx,
  output logic         done
);

  localparam int          NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
  localparam logic [15:0] NW_LAST    = 16'(NUM_OF_WORDS - 1);
  localparam logic [15:0] LAST_BLK   = 16'(NUM_BLOCKS - 1);

  state_e         state_q, state_d;
  logic [15:0]    base_q;
  logic [15:0]    n_q;
  logic [15:0]    rd_n_q;
  logic [4:0]     cyc_q;
  logic [15:0]    blk_q;
  logic [511:0]   block_data_q;
  logic           block_last_q;
  logic [15:0]    mem_addr_q;
  logic [31:0]    pad_word;
  logic           handshake;

  // Reads past the message end stay parked on its last word; the data is discarded.
  function automatic logic [15:0] clamp_n(input logic [15:0] x);
    return (x > NW_LAST) ? NW_LAST : x;
  endfunction

  sha256_pad_word_sel #(
    .NUM_OF_WORDS(NUM_OF_WORDS)
  ) u_pad_word_sel (
    .n_i       (n_q),
    .mem_word_i(mem_read_data),
    .word_o    (pad_word)
  );

  assign handshake   = (state_q == OUT) && block_ready;
  assign block_valid = (state_q == OUT);
  assign done        = (state_q == IDLE);
  assign block_data  = block_data_q;
  assign block_last  = block_last_q;
  assign block_idx   = blk_q[7:0];
  assign mem_addr    = mem_addr_q;
  assign mem_we      = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: if (cyc_q == 5'd16) state_d = OUT;
      OUT:  if (handshake) state_d = block_last_q ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // rd_n_q tracks the word being addressed, n_q the word arriving on mem_read_data one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q       <= 16'h0;
      n_q          <= 16'h0;
      rd_n_q       <= 16'h0;
      cyc_q        <= 5'd0;
      blk_q        <= 16'h0;
      block_data_q <= '0;
      block_last_q <= 1'b0;
      mem_addr_q   <= 16'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q       <= message_addr;
            mem_addr_q   <= message_addr;
            n_q          <= 16'h0;
            rd_n_q       <= 16'h0;
            cyc_q        <= 5'd0;
            blk_q        <= 16'h0;
            block_last_q <= 1'b0;
          end
        end
        LOAD: begin
          cyc_q <= cyc_q + 5'd1;
          if (cyc_q < 5'd15) begin
            rd_n_q     <= rd_n_q + 16'd1;
            mem_addr_q <= base_q + clamp_n(rd_n_q + 16'd1);
          end
          if (cyc_q != 5'd0) begin
            block_data_q <= {block_data_q[479:0], pad_word};
            n_q          <= n_q + 16'd1;
          end
          if (cyc_q == 5'd16) begin
            block_last_q <= (blk_q == LAST_BLK);
          end
        end
        OUT: begin
          if (handshake) begin
            block_last_q <= 1'b0;
            if (!block_last_q) begin
              blk_q      <= blk_q + 16'd1;
              cyc_q      <= 5'd0;
              rd_n_q     <= n_q;
              mem_addr_q <= base_q + clamp_n(n_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - scoreboard bench for sha256_msg_padder with NW=20, 13 and 14 instances
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [2:0]   start, vld, rdy, last, done, we;
  logic [15:0]  base [3];
  logic [15:0]  ma   [3];
  logic [31:0]  rd   [3];
  logic [511:0] bd   [3];
  logic [7:0]   bi   [3];

  sha256_msg_padder #(.NUM_OF_WORDS(20)) u_nw20 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .message_addr(base[0]),
    .mem_addr(ma[0]), .mem_we(we[0]), .mem_read_data(rd[0]), .block_data(bd[0]),
    .block_valid(vld[0]), .block_ready(rdy[0]), .block_last(last[0]),
    .block_idx(bi[0]), .done(done[0]));

  sha256_msg_padder #(.NUM_OF_WORDS(13)) u_nw13 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .message_addr(base[1]),
    .mem_addr(ma[1]), .mem_we(we[1]), .mem_read_data(rd[1]), .block_data(bd[1]),
    .block_valid(vld[1]), .block_ready(rdy[1]), .block_last(last[1]),
    .block_idx(bi[1]), .done(done[1]));

  sha256_msg_padder #(.NUM_OF_WORDS(14)) u_nw14 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .message_addr(base[2]),
    .mem_addr(ma[2]), .mem_we(we[2]), .mem_read_data(rd[2]), .block_data(bd[2]),
    .block_valid(vld[2]), .block_ready(rdy[2]), .block_last(last[2]),
    .block_idx(bi[2]), .done(done[2]));

  // Memory image: mem[k] = k, except one distinctive word at 0x0300.
  function automatic logic [31:0] memval(input logic [15:0] a);
    return (a == 16'h0300) ? 32'h11223344 : {16'h0, a};
  endfunction

  function automatic logic [31:0] img(input logic [31:0] w);
`ifdef SHA_PAD_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] exp_word(input int nw, input logic [15:0] b, input int n);
    int nb;
    nb = (nw + 18) / 16;
    if (n < nw) return img(memval(b + 16'(n)));
    if (n == nw) return 32'h8000_0000;
    if (n == nb * 16 - 1) return 32'(nw * 32);
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rd[i] <= memval(ma[i]);
  end

  typedef struct {
    int           inst;
    logic [511:0] data;
    logic         lst;
    logic [7:0]   idx;
  } blk_t;

  blk_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   hs_cnt = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_run(input int inst, input int nw, input logic [15:0] b);
    int nb;
    blk_t e;
    nb = (nw + 18) / 16;
    for (int k = 0; k < nb; k++) begin
      e.inst = inst;
      e.lst  = (k == nb - 1);
      e.idx  = 8'(k);
      for (int w = 0; w < 16; w++) e.data[511 - 32 * w -: 32] = exp_word(nw, b, k * 16 + w);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-stability under backpressure.
  initial begin : monitor
    logic [511:0] prev_bd [3];
    logic [7:0]   prev_bi [3];
    logic [2:0]   prev_hold;
    blk_t         e;
    prev_hold = 3'b000;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!reset_n) begin
          prev_hold[i] = 1'b0;
        end else begin
          if (prev_hold[i] && vld[i]) begin
            chk("hold_data", bd[i], prev_bd[i]);
            chk("hold_idx", bi[i], prev_bi[i]);
          end
          if (vld[i] && rdy[i]) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_block: inst %0d idx %0d with nothing expected", i, bi[i]);
            end else begin
              e = exp_q.pop_front();
              chk("block_inst", i, e.inst);
              chk("block_data", bd[i], e.data);
              chk("block_last", last[i], e.lst);
              chk("block_idx", bi[i], e.idx);
            end
          end
          prev_hold[i] = vld[i] && !rdy[i];
          prev_bd[i]   = bd[i];
          prev_bi[i]   = bi[i];
        end
      end
    end
  end

  task automatic wait_hs(input int target);
    int c;
    c = 0;
    while (hs_cnt < target && c < 600) begin
      @(posedge clk);
      c++;
    end
    chk("handshake_timeout", hs_cnt, target);
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
  endtask

  // Drives start and returns posedges until block_valid; an optional stray start pulse at cycle 5.
  task automatic start_latency(input int i, input bit stray, output int cnt);
    @(posedge clk); #1 start[i] = 1'b1;
    cnt = 0;
    while (cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
      start[i] = (stray && cnt == 5);
      if (vld[i]) break;
    end
    start[i] = 1'b0;
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    start   = 3'b000;
    rdy     = 3'b000;
    for (int i = 0; i < 3; i++) base[i] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", vld, 3'b000);
    chk("rst_done", done, 3'b111);
    chk("rst_last", last, 3'b000);
    chk("rst_idx", bi[0], 8'h0);
    chk("rst_addr", ma[0], 16'h0);
    chk("rst_data", bd[0], 512'h0);
    chk("mem_we", we, 3'b000);
    reset_n = 1'b1;

    // NW=20, two blocks, ready held high
    push_run(0, 20, 16'h0);
    rdy[0] = 1'b1;
    pulse_start(0);
    wait_hs(2);

    // NW=13 from base 0x0300, single block, latency
    base[1] = 16'h0300;
    push_run(1, 13, 16'h0300);
    rdy[1] = 1'b1;
    start_latency(1, 1'b0, lat);
    chk("latency_nw13", lat, 18);
    wait_hs(3);

    // NW=14: pad word and length split across blocks
    push_run(2, 14, 16'h0);
    rdy[2] = 1'b1;
    pulse_start(2);
    wait_hs(5);

    // Backpressure on NW=20
    rdy[0] = 1'b0;
    push_run(0, 20, 16'h0);
    start_latency(0, 1'b0, lat);
    chk("latency_nw20", lat, 18);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid", vld[0], 1'b1);
    end
    rdy[0] = 1'b1;
    wait_hs(7);
    repeat (40) @(posedge clk);
    chk("bp_handshakes", hs_cnt, 7);

    // Stray start during LOAD must not restart the run
    push_run(0, 20, 16'h0);
    start_latency(0, 1'b1, lat);
    chk("latency_stray_start", lat, 18);
    wait_hs(9);

    // Reset mid-LOAD discards the partial block
    pulse_start(0);
    repeat (8) @(posedge clk);
    #1;
    chk("in_load_done", done[0], 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", vld[0], 1'b0);
    chk("midrst_done", done[0], 1'b1);
    chk("midrst_data", bd[0], 512'h0);
    chk("midrst_idx", bi[0], 8'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    push_run(0, 20, 16'h0);
    pulse_start(0);
    wait_hs(11);

    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("total_handshakes", hs_cnt, 11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
